// File: rtl/mcse_top.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mcse_top : MCSE boot/lifecycle controller, all host handshakes on GPIO.
// Optional IP-ID framing check: MCSE_FRAME_CHECK_EN.          Rev 1.0
// -----------------------------------------------------------------------------
module mcse_top #(
  parameter int           GPIO_N     = 32,
  parameter int           IPID_N     = 3,
  parameter int           IPID_WIDTH = 256,
  parameter logic [255:0] TID_TEST   = 256'h33a344a35afd82155e5a6ef2d092085d704dc70561dde45d27962d79ea56a24a,
  parameter logic [255:0] AID_OEM    = 256'h431909d9da263164ab4d39614e0c50a32774a49b3390a53ffa63e8d74b8e7c0b,
  parameter logic [255:0] TID_OEM    = 256'h988b6a57b75f5696f01b8207b1c99bc888b4a2421a0ab4b29bd302f5b8a93348,
  parameter logic [255:0] AID_DEP    = 256'h8e30701845bea3e44d0aed1ba6d4893a0de91fea6f42571d3714a3c6daa39978,
  parameter logic [255:0] TID_DEP    = 256'h4893565d146d9fa19dc850e0c409b2a62ec5cb53eea4d4719c93a882f988284e,
  parameter logic [255:0] AID_RCL    = 256'hd995f5ddfb1625e3a33b0ee123b6672f35df88d6652eaec51d26f3a50b030ad8,
  parameter logic [255:0] TID_RCL    = 256'hcabc36e4f52fcd1a8b62d82d975e4c8595da7f6df52e2143174c3dc8b3870e03,
  parameter logic [255:0] AID_EOL    = 256'hdf0f326b1bf6611d944491d7a0618af56ac57e391ba38425f9f33cafdd7439a9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_config_n,
  input  logic [GPIO_N-1:0] gpio_in,
  input  logic              lc_transition_request_in,
  input  logic [255:0]      lc_transition_id,
  input  logic              lc_authentication_valid,
  input  logic [255:0]      lc_authentication_id,
  output logic [GPIO_N-1:0] gpio_out
);

  localparam int             WORDS        = IPID_WIDTH / 16;
  localparam int             WCW          = $clog2(WORDS + 2);
  localparam logic [WCW-1:0] LAST_PAYLOAD = WCW'(WORDS);
  localparam logic [3:0]     LAST_IP      = 4'(IPID_N - 1);
  localparam logic [15:0]    HDR_WORD     = 16'h7A7A;
  localparam logic [15:0]    TRL_WORD     = 16'hB9B9;
  localparam logic [2:0]     LC_TEST      = 3'd0;
  localparam logic [2:0]     LC_OEM       = 3'd1;
  localparam logic [2:0]     LC_DEP       = 3'd2;
  localparam logic [2:0]     LC_RCL       = 3'd3;
  localparam logic [2:0]     LC_EOL       = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_BOOT_RST, S_AUTH, S_WAKE, S_IPID, S_RELEASE,
    S_OPER, S_TRN_RST, S_TRN_GAP, S_LOCKED, S_HALT
  } state_t;

  state_t                               state;
  logic                                 rst_req, op_rel, wake, ip_trig, locked, frame_err;
  logic [3:0]                           ip_addr;
  logic [2:0]                           lc;
  logic [WCW-1:0]                       word_cnt;
  logic                                 gap, retry;
  logic [IPID_WIDTH-1:0]                frame_sr;
  logic [IPID_N-1:0][IPID_WIDTH-1:0]    ip_store;
  logic [15:0]                          word;
  logic                                 frame_ok;
  logic                                 tid_hit;
  logic                                 unused_bits;

  function automatic logic [255:0] aid_of(input logic [2:0] code);
    case (code)
      LC_OEM:  aid_of = AID_OEM;
      LC_DEP:  aid_of = AID_DEP;
      LC_RCL:  aid_of = AID_RCL;
      LC_EOL:  aid_of = AID_EOL;
      default: aid_of = '0;
    endcase
  endfunction

  function automatic logic [255:0] tid_of(input logic [2:0] code);
    case (code)
      LC_TEST: tid_of = TID_TEST;
      LC_OEM:  tid_of = TID_OEM;
      LC_DEP:  tid_of = TID_DEP;
      LC_RCL:  tid_of = TID_RCL;
      default: tid_of = '0;
    endcase
  endfunction

  assign word    = gpio_in[31:16];
  assign tid_hit = lc_transition_request_in && (lc < LC_EOL) && (lc_transition_id == tid_of(lc));

`ifdef MCSE_FRAME_CHECK_EN
  logic hdr_bad;
  assign frame_ok = !hdr_bad && (word == TRL_WORD);
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rst_req   <= 1'b0;
      op_rel    <= 1'b0;
      wake      <= 1'b0;
      ip_trig   <= 1'b0;
      ip_addr   <= '0;
      lc        <= LC_TEST;
      locked    <= 1'b0;
      frame_err <= 1'b0;
      word_cnt  <= '0;
      gap       <= 1'b0;
      retry     <= 1'b0;
      frame_sr  <= '0;
      ip_store  <= '0;
`ifdef MCSE_FRAME_CHECK_EN
      hdr_bad   <= 1'b0;
`endif
    end else if (!init_config_n && state != S_LOCKED && state != S_HALT) begin
      state    <= S_IDLE;
      rst_req  <= 1'b0;
      op_rel   <= 1'b0;
      wake     <= 1'b0;
      ip_trig  <= 1'b0;
      ip_addr  <= '0;
      word_cnt <= '0;
      retry    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state   <= S_BOOT_RST;
          rst_req <= 1'b1;
        end
        S_BOOT_RST: if (gpio_in[1]) begin
          rst_req <= 1'b0;
          if (lc == LC_TEST) begin
            state <= S_WAKE;
            wake  <= 1'b1;
          end else begin
            state <= S_AUTH;
          end
        end
        S_AUTH: if (lc_authentication_valid) begin
          if (lc_authentication_id != aid_of(lc)) begin
            state  <= S_LOCKED;
            locked <= 1'b1;
          end else if (lc == LC_EOL) begin
            state <= S_HALT;
          end else begin
            state <= S_WAKE;
            wake  <= 1'b1;
          end
        end
        S_WAKE: if (gpio_in[7]) begin
          wake     <= 1'b0;
          state    <= S_IPID;
          ip_addr  <= '0;
          ip_trig  <= 1'b1;
          word_cnt <= '0;
        end
        S_IPID: begin
          if (ip_trig) begin
            if (gpio_in[13]) begin
              word_cnt <= word_cnt + 1'b1;
              if (word_cnt == '0) begin
`ifdef MCSE_FRAME_CHECK_EN
                hdr_bad <= (word != HDR_WORD);
`endif
              end else if (word_cnt <= LAST_PAYLOAD) begin
                frame_sr <= {frame_sr[IPID_WIDTH-17:0], word};
              end else begin
                ip_trig  <= 1'b0;
                gap      <= 1'b0;
                word_cnt <= '0;
                if (frame_ok) begin
                  retry <= 1'b0;
                  for (int i = 0; i < IPID_N; i++)
                    if (ip_addr == 4'(i)) ip_store[i] <= frame_sr;
                end else begin
                  frame_err <= 1'b1;
                  retry     <= 1'b1;
                  frame_sr  <= '0;
                end
              end
            end else begin
              // valid dropped mid-frame: the host restarts from the header
              word_cnt <= '0;
            end
          end else if (!gap) begin
            gap <= 1'b1;
          end else if (retry) begin
            retry   <= 1'b0;
            ip_trig <= 1'b1;
          end else if (ip_addr == LAST_IP) begin
            ip_addr <= '0;
            if (lc == LC_TEST) begin
              state <= S_OPER;
            end else begin
              state  <= S_RELEASE;
              op_rel <= 1'b1;
            end
          end else begin
            ip_addr <= ip_addr + 1'b1;
            ip_trig <= 1'b1;
          end
        end
        S_RELEASE: if (gpio_in[5]) begin
          op_rel <= 1'b0;
          state  <= S_OPER;
        end
        S_OPER: if (tid_hit) begin
          state   <= S_TRN_RST;
          rst_req <= 1'b1;
        end
        S_TRN_RST: if (gpio_in[1]) begin
          rst_req <= 1'b0;
          lc      <= lc + 3'd1;
          state   <= S_TRN_GAP;
        end
        S_TRN_GAP: begin
          rst_req <= 1'b1;
          state   <= S_BOOT_RST;
        end
        S_LOCKED, S_HALT: begin
          state <= state;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign gpio_out = {{(GPIO_N-18){1'b0}}, frame_err, locked, lc, ip_trig, ip_addr,
                     1'b0, wake, 1'b0, op_rel, 3'b000, rst_req};

  assign unused_bits = ^{gpio_in[0], gpio_in[4:2], gpio_in[6], gpio_in[12:8], gpio_in[15:14], ip_store};

endmodule
`default_nettype wire

// File: tb/tb_mcse_top.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mcse_top : host model and scoreboard for mcse_top boot/lifecycle flow.
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_mcse_top;

  localparam logic [255:0] TID_TEST = 256'h33a344a35afd82155e5a6ef2d092085d704dc70561dde45d27962d79ea56a24a;
  localparam logic [255:0] AID_OEM  = 256'h431909d9da263164ab4d39614e0c50a32774a49b3390a53ffa63e8d74b8e7c0b;
  localparam logic [255:0] TID_OEM  = 256'h988b6a57b75f5696f01b8207b1c99bc888b4a2421a0ab4b29bd302f5b8a93348;
  localparam logic [255:0] AID_DEP  = 256'h8e30701845bea3e44d0aed1ba6d4893a0de91fea6f42571d3714a3c6daa39978;
  localparam logic [255:0] TID_DEP  = 256'h4893565d146d9fa19dc850e0c409b2a62ec5cb53eea4d4719c93a882f988284e;
  localparam logic [255:0] AID_RCL  = 256'hd995f5ddfb1625e3a33b0ee123b6672f35df88d6652eaec51d26f3a50b030ad8;
  localparam logic [255:0] TID_RCL  = 256'hcabc36e4f52fcd1a8b62d82d975e4c8595da7f6df52e2143174c3dc8b3870e03;
  localparam logic [255:0] AID_EOL  = 256'hdf0f326b1bf6611d944491d7a0618af56ac57e391ba38425f9f33cafdd7439a9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init_config_n = 1'b0;
  logic [31:0]  gpio_in = '0;
  logic         lc_transition_request_in = 1'b0;
  logic [255:0] lc_transition_id = '0;
  logic         lc_authentication_valid = 1'b0;
  logic [255:0] lc_authentication_id = '0;
  logic [31:0]  gpio_out;

  int total = 0;
  int bad   = 0;
  int lc_m  = 0;
  int err_m = 0;
  logic [31:0] sb_q[$];
  string       sb_tag[$];

  mcse_top dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .init_config_n            (init_config_n),
    .gpio_in                  (gpio_in),
    .lc_transition_request_in (lc_transition_request_in),
    .lc_transition_id         (lc_transition_id),
    .lc_authentication_valid  (lc_authentication_valid),
    .lc_authentication_id     (lc_authentication_id),
    .gpio_out                 (gpio_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // expected gpio_out: requested bits plus the modelled lifecycle and sticky error
  function automatic logic [31:0] gv(input logic [31:0] bits);
    return bits | (32'(lc_m) << 13) | (32'(err_m) << 17);
  endfunction

  function automatic logic [255:0] tid_of(input int code);
    case (code)
      0: return TID_TEST;
      1: return TID_OEM;
      2: return TID_DEP;
      default: return TID_RCL;
    endcase
  endfunction

  function automatic logic [255:0] aid_of(input int code);
    case (code)
      1: return AID_OEM;
      2: return AID_DEP;
      3: return AID_RCL;
      default: return AID_EOL;
    endcase
  endfunction

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb_q.push_back(v);
    sb_tag.push_back(tag);
  endtask

  task automatic sb_pop();
    if (sb_q.size() == 0) check("sb_underflow", 32'(sb_q.size()), 32'd1);
    else check(sb_tag.pop_front(), gpio_out, sb_q.pop_front());
  endtask

  task automatic wait_bit(input int b, input logic v, input int budget, input string tag);
    int n = 0;
    while (gpio_out[b] !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (gpio_out[b] !== v) check({tag, "_timeout"}, {31'b0, gpio_out[b]}, {31'b0, v});
  endtask

  task automatic handshake(input int req, input int ack, input string tag, input bit do_pop);
    wait_bit(req, 1'b1, 50, tag);
    if (do_pop) sb_pop();
    gpio_in[ack] = 1'b1;
    wait_bit(req, 1'b0, 10, {tag, "_drop"});
    gpio_in[ack] = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    init_config_n = 1'b0;
    gpio_in = '0;
    lc_transition_request_in = 1'b0;
    lc_authentication_valid = 1'b0;
    lc_m = 0;
    err_m = 0;
    repeat (10) @(negedge clk);
    check("reset", gpio_out, 32'h0);
    rst_n = 1'b1;
    init_config_n = 1'b1;
    sb_push("boot_req", gv(32'h1));
    wait_bit(0, 1'b1, 3, "boot_req");
    sb_pop();
  endtask

  task automatic send_frame(input logic [15:0] trailer, input int drop_at);
    wait_bit(12, 1'b1, 20, "ip_trig");
    sb_pop();
    if (drop_at > 0) begin
      for (int w = 0; w < drop_at; w++) begin
        gpio_in[13] = 1'b1;
        gpio_in[31:16] = (w == 0) ? 16'h7A7A : 16'($urandom);
        @(negedge clk);
      end
      gpio_in[13] = 1'b0;
      @(negedge clk);
    end
    for (int w = 0; w < 18; w++) begin
      gpio_in[13] = 1'b1;
      gpio_in[31:16] = (w == 0) ? 16'h7A7A : (w == 17) ? trailer : 16'($urandom);
      if (w == 17) check("trig_before_trailer", {31'b0, gpio_out[12]}, 32'd1);
      @(negedge clk);
    end
    gpio_in[13] = 1'b0;
    check("trig_drop", {31'b0, gpio_out[12]}, 32'd0);
    @(negedge clk);
    check("trig_gap", {31'b0, gpio_out[12]}, 32'd0);
  endtask

  task automatic transition();
    sb_push("trn_req", gv(32'h1));
    lc_transition_request_in = 1'b1;
    lc_transition_id = tid_of(lc_m);
    wait_bit(0, 1'b1, 20, "trn_req");
    sb_pop();
    lc_transition_request_in = 1'b0;
    gpio_in[1] = 1'b1;
    wait_bit(0, 1'b0, 10, "trn_ack");
    lc_m++;
    check("lc_adv", gpio_out, gv(32'h0));
    gpio_in[1] = 1'b0;
    @(negedge clk);
    check("reboot_gap", gpio_out, gv(32'h1));
  endtask

  task automatic run_boot(input bit bad_tr, input bit drop);
    int  ip = 0;
    bit  retried = 1'b0;
    logic [15:0] tr;
    handshake(0, 1, "boot_rst", 1'b0);
    sb_push("wake_req", gv(32'h40));
    if (lc_m != 0) begin
      lc_authentication_valid = 1'b1;
      lc_authentication_id = aid_of(lc_m);
    end
    handshake(6, 7, "wake", 1'b1);
    lc_authentication_valid = 1'b0;
    while (ip < 3) begin
      sb_push($sformatf("ip%0d_req", ip), gv(32'h1000 | (32'(ip) << 8)));
      tr = (bad_tr && ip == 0 && !retried) ? 16'h1234 : 16'hB9B9;
      send_frame(tr, (drop && ip == 1) ? 5 : 0);
      if (tr == 16'h1234) begin
        retried = 1'b1;
`ifdef MCSE_FRAME_CHECK_EN
        err_m = 1;
`else
        ip++;
`endif
      end else begin
        ip++;
      end
    end
    if (lc_m != 0) begin
      sb_push("rel_req", gv(32'h10));
      handshake(4, 5, "release", 1'b1);
    end
    repeat (4) @(negedge clk);
    if (lc_m == 0) begin
      lc_transition_request_in = 1'b1;
      lc_transition_id = TID_OEM;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        check("wrong_tid", gpio_out, gv(32'h0));
      end
      lc_transition_request_in = 1'b0;
      @(negedge clk);
    end
    transition();
  endtask

  task automatic auth_no_wake(input logic [255:0] id, input string tag, input logic [31:0] bits);
    bit wake_seen = 1'b0;
    handshake(0, 1, {tag, "_rst"}, 1'b0);
    lc_authentication_valid = 1'b1;
    lc_authentication_id = id;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gpio_out[6]) wake_seen = 1'b1;
    end
    lc_authentication_valid = 1'b0;
    check({tag, "_state"}, gpio_out, gv(bits));
    check({tag, "_no_wake"}, {31'b0, wake_seen}, 32'd0);
  endtask

  initial begin
    reset_dut();
    run_boot(1'b0, 1'b1);
    repeat (3) run_boot(1'b0, 1'b0);
    auth_no_wake(AID_EOL, "eol", 32'h0);
    reset_dut();
    run_boot(1'b1, 1'b0);
    auth_no_wake(AID_DEP, "lock", 32'h10000);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
